// File: rtl/alu_seq_param.sv
// Handshaked, parametrised ALU: single-cycle logic/arith ops plus an iterative shift-add multiply.
// Operands enter on a valid/ready channel; registered results leave on a valid/ready channel.
module alu_seq_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   op_result;
    logic               op_carry;
    logic               op_ovf;
    logic [2*WIDTH-1:0] acc_next;

    // Draining DONE and accepting in the same edge keeps single-cycle ops at full throughput.
    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);

    // NOTE: every output of an always_comb gets a default before the case, so no latch is inferred.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
        diff      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        op_result = '0;
        op_carry  = 1'b0;
        op_ovf    = 1'b0;
        case (alu_op)
            OP_AND: op_result = a & b;
            OP_OR:  op_result = a | b;
            OP_NOR: op_result = ~(a | b);
            OP_ADD: begin
                op_result = sum[WIDTH-1:0];
                op_carry  = sum[WIDTH];
                op_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_result = diff[WIDTH-1:0];
                op_carry  = diff[WIDTH];
                op_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: ;
        endcase
    end

    // Multiplicand is pre-shifted each cycle, so it already carries the iteration weight.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (alu_op == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= CNT_W'(WIDTH);
                            state  <= S_MUL;
                        end else begin
                            result    <= op_result;
                            carry_out <= op_carry;
                            overflow  <= op_ovf;
                            zero      <= (op_result == '0);
                            state     <= S_DONE;
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result    <= acc_next[WIDTH-1:0];
                        carry_out <= |acc_next[2*WIDTH-1:WIDTH];
                        overflow  <= 1'b0;
                        zero      <= (acc_next[WIDTH-1:0] == '0);
                        state     <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
